// File: rtl/mc_control.sv
// mc_control -- multicycle MIPS-style control unit.
//
// Walks each instruction through FETCH, DECODE and the states that
// instruction needs, driving the datapath control strobes from the
// current state. The opcode is captured in DECODE so that later states
// do not depend on the instruction register staying stable.
//
// Ports:
//   clk         rising-edge clock
//   resetN      asynchronous active-low reset; forces FETCH and all-zero outputs
//   opCode      instruction bits [31:26], looked at only in DECODE
//   mem_ready   memory finishes the current access this cycle
//   PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
//   RegDst, RegWrite, ALUSrcA, ALUSrcB[1:0], ALUOp[1:0], PCSource[1:0]
//               datapath controls
//   state       current state encoding (debug)
//   instr_done  pulse on the final cycle of an instruction
//   illegal_op  pulse in DECODE when the opcode is not supported
module mc_control (
  input  logic       clk,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic [3:0] state,
  output logic       instr_done,
  output logic       illegal_op
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXEC   = 4'd6,
    ALUWB  = 4'd7,
    BRANCH = 4'd8,
    ADDIEX = 4'd9,
    ADDIWB = 4'd10,
    JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  state_t     cur_state;
  logic [5:0] op_reg;

  assign state = cur_state;

  // State register and transition logic. The opcode is latched in DECODE
  // because MEMADR must still tell lw from sw a cycle later, after the
  // instruction register may already have changed. Unused encodings
  // (12-15) fall back to FETCH through the default branch.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      cur_state <= FETCH;
      op_reg    <= '0;
    end else begin
      case (cur_state)
        FETCH:  if (mem_ready) cur_state <= DECODE;
        DECODE: begin
          op_reg <= opCode;
          case (opCode)
            OP_RTYPE:    cur_state <= EXEC;
            OP_LW, OP_SW: cur_state <= MEMADR;
            OP_BEQ:      cur_state <= BRANCH;
            OP_ADDI:     cur_state <= ADDIEX;
            OP_J:        cur_state <= JUMP;
            default:     cur_state <= FETCH;
          endcase
        end
        MEMADR: cur_state <= (op_reg == OP_LW) ? MEMRD : MEMWR;
        MEMRD:  if (mem_ready) cur_state <= MEMWB;
        MEMWB:  cur_state <= FETCH;
        MEMWR:  if (mem_ready) cur_state <= FETCH;
        EXEC:   cur_state <= ALUWB;
        ALUWB:  cur_state <= FETCH;
        BRANCH: cur_state <= FETCH;
        ADDIEX: cur_state <= ADDIWB;
        ADDIWB: cur_state <= FETCH;
        JUMP:   cur_state <= FETCH;
        default: cur_state <= FETCH;
      endcase
    end
  end

  // Output decode from the current state. Everything defaults to zero and
  // the whole decode is suppressed while resetN is low, so reset silences
  // the strobes immediately (even MemRead in FETCH, and any instr_done of
  // an aborted access) without waiting for a clock edge. PCWrite/IRWrite
  // in FETCH and instr_done in MEMWR follow mem_ready so the PC and IR only
  // load, and a store only retires, on the cycle the memory completes.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    if (resetN) begin
      case (cur_state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          PCWrite = mem_ready;
          IRWrite = mem_ready;
        end
        DECODE: begin
          ALUSrcB = 2'b11;
          case (opCode)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
            default: illegal_op = 1'b1;
          endcase
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        EXEC: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        ALUWB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        ADDIWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/mc_control.md
MC_CONTROL -- requirements
Module: mc_control

Interface
REQ-001 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge.
- resetN  in  1  asynchronous, active-low reset.
- opCode  in  6  instruction register bits [31:26]; sampled only in DECODE.
- mem_ready  in  1  memory completes the current access this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (beq).
- IorD  out  1  memory address select: 0 = PC, 1 = ALUOut.
- MemRead  out  1  memory read strobe.
- MemWrite  out  1  memory write strobe.
- IRWrite  out  1  instruction register load.
- MemtoReg  out  1  register write data: 0 = ALUOut, 1 = MDR.
- RegDst  out  1  destination register: 0 = rt, 1 = rd.
- RegWrite  out  1  register file write enable.
- ALUSrcA  out  1  ALU A: 0 = PC, 1 = rs.
- ALUSrcB  out  2  ALU B: 00 = rt, 01 = const 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2.
- ALUOp  out  2  00 = add, 01 = subtract, 10 = funct field decides.
- PCSource  out  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  out  4  current state encoding, for debug and verification.
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction.
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opCode.

Function
REQ-002 The block SHALL be a Moore FSM with these states and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
REQ-003 Encodings 12-15 SHALL transition to FETCH on the next clock, with all outputs 0.
REQ-004 FETCH SHALL drive MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
REQ-005 In FETCH, PCWrite and IRWrite SHALL equal mem_ready.
REQ-006 FETCH SHALL go to DECODE when mem_ready=1 and hold otherwise; there is no stall limit.
REQ-007 DECODE SHALL drive ALUSrcA=0, ALUSrcB=11, ALUOp=00 and branch on opCode as follows:
- 000000 -> EXEC
- 100011 (lw) or 101011 (sw) -> MEMADR
- 000100 (beq) -> BRANCH
- 001000 (addi) -> ADDIEX
- 000010 (j) -> JUMP
- any other opCode -> FETCH, with illegal_op=1 for that cycle.
REQ-008 MEMADR SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to MEMRD for lw or MEMWR for sw.
REQ-009 Because of REQ-008, opCode SHALL be registered at DECODE; later states SHALL use the registered copy.
REQ-010 MEMRD SHALL drive MemRead=1, IorD=1, hold while mem_ready=0, and go to MEMWB when mem_ready=1.
REQ-011 MEMWB SHALL drive RegWrite=1, MemtoReg=1, RegDst=0 and instr_done=1, then go to FETCH.
REQ-012 MEMWR SHALL drive MemWrite=1 and IorD=1 while holding for mem_ready; it SHALL assert instr_done=1 and go to FETCH on the cycle mem_ready=1.
REQ-013 EXEC SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=10, then go to ALUWB.
REQ-014 ALUWB SHALL drive RegWrite=1, RegDst=1, MemtoReg=0 and instr_done=1, then go to FETCH.
REQ-015 BRANCH SHALL drive ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01 and instr_done=1, then go to FETCH.
REQ-016 ADDIEX SHALL drive ALUSrcA=1, ALUSrcB=10, ALUOp=00, then go to ADDIWB.
REQ-017 ADDIWB SHALL drive RegWrite=1, RegDst=0, MemtoReg=0 and instr_done=1, then go to FETCH.
REQ-018 JUMP SHALL drive PCWrite=1, PCSource=10 and instr_done=1, then go to FETCH.
REQ-019 Any output not listed for a state SHALL be 0 in that state; outputs SHALL never be X.
REQ-020 MemRead and MemWrite SHALL never be 1 in the same cycle.
REQ-021 RegWrite SHALL be 1 only in MEMWB, ALUWB and ADDIWB.
REQ-022 Latency with mem_ready tied to 1 SHALL be:
- lw 5 cycles
- sw, R-type and addi 4 cycles each
- beq and j 3 cycles each.
REQ-023 Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle to the instruction's latency.

Reset
REQ-024 While resetN=0, state SHALL be FETCH and every output SHALL be 0, including MemRead in FETCH, regardless of clk.
REQ-025 On the first rising clk edge after resetN rises, state SHALL be FETCH with normal FETCH outputs.
REQ-026 Reset asserted in any state, including mid-access in MEMRD or MEMWR, SHALL abort the instruction immediately; no instr_done SHALL be produced for the aborted instruction.

Verification
REQ-027 Reset: assert resetN=0 asynchronously during MEMWR -> all outputs 0 in the same cycle, state=0; release -> FETCH.
REQ-028 lw, mem_ready=1 throughout: opCode=100011 -> state sequence 0,1,2,3,4; RegWrite=1 only in cycle 5; instr_done pulses once.
REQ-029 lw with stalls: mem_ready=0 for 2 cycles in FETCH and 3 cycles in MEMRD -> 10-cycle instruction; PCWrite=1 only on the ready cycle of FETCH.
REQ-030 R-type then beq back to back: opCode 000000, then 000100 -> states 0,1,6,7,0,1,8; ALUOp=10 in EXEC and 01 in BRANCH; PCWriteCond=1 only in state 8.
REQ-031 Illegal opcode: opCode=111111 -> states 0,1,0; illegal_op=1 for one cycle in DECODE; no RegWrite or MemWrite.
REQ-032 Opcode change after DECODE: opCode=101011 at DECODE, then changed to 100011 -> MEMADR goes to MEMWR, not MEMRD, because the registered opcode is used.
